// File: rtl/ysyx_22051013_if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// presents pc/inst pairs to IF/ID, honouring stall backpressure and redirects.
module ysyx_22051013_if_fetch #(
  parameter int unsigned      XLEN     = 64,
  parameter int unsigned      INST_W   = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_pc_stall,
  input  logic              jump_ena,
  input  logic [XLEN-1:0]   jump_pc,
  output logic              imem_req_valid,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_inst,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst
);

  // Request channel: a transfer happens on a rising edge where imem_req_valid
  // and imem_req_ready are both high; once raised, valid stays high with a
  // stable address until that edge (a redirect counts as a fresh request).
  // Response channel has no ready: imem_rsp_valid is a one-cycle pulse.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                drop_q, drop_d;
  logic [INST_W-1:0]   hold_inst_q, hold_inst_d;
  logic [XLEN-1:0]     pc_inc;

  assign pc_inc        = pc_q + XLEN'(4);
  assign imem_req_addr = pc_q;
  assign if_pc         = pc_q;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drop_d         = drop_q;
    hold_inst_d    = hold_inst_q;
    imem_req_valid = 1'b0;
    if_valid       = 1'b0;
    if_inst        = '0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (jump_ena) pc_d = jump_pc;
      end

      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d = S_WAIT;
          // Accepted with the old address while redirecting: its reply is stale.
          drop_d  = jump_ena;
        end
        if (jump_ena) pc_d = jump_pc;
      end

      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (jump_ena) begin
            pc_d    = jump_pc;
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            if_valid = 1'b1;
            if_inst  = imem_rsp_inst;
            if (if_pc_stall) begin
              hold_inst_d = imem_rsp_inst;
              state_d     = S_HOLD;
            end else begin
              pc_d    = pc_inc;
              state_d = S_REQ;
            end
          end
        end else if (jump_ena) begin
          pc_d   = jump_pc;
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (jump_ena) begin
          pc_d        = jump_pc;
          hold_inst_d = '0;
          state_d     = S_REQ;
        end else begin
          if_valid = 1'b1;
          if_inst  = hold_inst_q;
          if (!if_pc_stall) begin
            pc_d    = pc_inc;
            state_d = S_REQ;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      hold_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      hold_inst_q <= hold_inst_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_if_fetch.sv
// Directed bench for the fetch stage: a transaction-level model of the PC and
// the outstanding fetch is compared with the DUT every cycle, plus literal checks.
module tb_ysyx_22051013_if_fetch;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_pc_stall;
  logic        jump_ena;
  logic [63:0] jump_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_inst;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_inst;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;
  logic stray_req;

  logic [63:0] acc_log[$];
  logic [63:0] cons_log[$];
  logic [31:0] dlv_inst[$];
  int          vld_cyc[$];

  ysyx_22051013_if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc_stall    (if_pc_stall),
    .jump_ena       (jump_ena),
    .jump_pc        (jump_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_inst  (imem_rsp_inst),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  // ---------------- clock / watchdog ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] mem_inst(input logic [63:0] a);
    return 32'h0010_0093 + (a[31:0] - 32'h8000_0000);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string nm, input logic [63:0] exp_addr);
    logic found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) found = 1'b1;
    end
    chk({nm, "_seen"}, 64'(found), 64'd1);
    if (found) chk(nm, imem_req_addr, exp_addr);
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_if_pc", if_pc, RST_PC);
    chk("rst_if_inst", 64'(if_inst), 64'd0);
    cyc();
    rst = 1'b1;
  endtask

  // ---------------- memory responder ----------------
  initial begin
    logic        pend;
    int          cnt;
    logic [63:0] a;
    pend = 1'b0;
    cnt  = 0;
    a    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_inst  = '0;
    forever begin
      @(negedge clk);
      if (!rst) pend = 1'b0;
      else if (imem_req_valid && imem_req_ready) begin
        pend = 1'b1;
        cnt  = lat;
        a    = imem_req_addr;
      end
      @(posedge clk);
      #2;
      imem_rsp_valid = 1'b0;
      imem_rsp_inst  = '0;
      if (stray_req) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_inst  = 32'hDEAD_BEEF;
      end else if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_inst  = mem_inst(a);
          pend = 1'b0;
        end
      end
    end
  end

  // ---------------- transaction model + per-cycle compare ----------------
  initial begin
    logic [63:0] m_pc;
    logic [63:0] out_addr;
    logic [31:0] held;
    logic        outstanding, stale, holding, prev_pend, exp_v, consumed;
    int          cyc_n;
    m_pc = RST_PC; out_addr = '0; held = '0;
    outstanding = 0; stale = 0; holding = 0; prev_pend = 0; cyc_n = 0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (!rst) begin
        chk("m_rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("m_rst_if_valid", 64'(if_valid), 64'd0);
        chk("m_rst_if_pc", if_pc, RST_PC);
        m_pc = RST_PC; outstanding = 0; stale = 0; holding = 0; prev_pend = 0;
      end else begin
        exp_v = !jump_ena && ((imem_rsp_valid && outstanding && !stale) || holding);
        chk("m_if_valid", 64'(if_valid), 64'(exp_v));
        if (exp_v) begin
          chk("m_if_pc", if_pc, m_pc);
          chk("m_if_inst", 64'(if_inst), 64'(holding ? held : mem_inst(out_addr)));
          vld_cyc.push_back(cyc_n);
          dlv_inst.push_back(if_inst);
        end
        if (prev_pend) chk("m_req_not_withdrawn", 64'(imem_req_valid), 64'd1);
        if (imem_req_valid) begin
          chk("m_req_addr", imem_req_addr, m_pc);
          chk("m_one_outstanding", 64'(outstanding || holding), 64'd0);
        end
        consumed = exp_v && !if_pc_stall;
        if (imem_rsp_valid && outstanding) begin
          outstanding = 0;
          if (!stale && !jump_ena && if_pc_stall) begin
            holding = 1;
            held    = mem_inst(out_addr);
          end
          stale = 0;
        end
        if (consumed) begin
          cons_log.push_back(m_pc);
          m_pc    = m_pc + 64'd4;
          holding = 0;
        end
        if (imem_req_valid && imem_req_ready) begin
          outstanding = 1;
          stale       = 0;
          out_addr    = imem_req_addr;
          acc_log.push_back(imem_req_addr);
        end
        if (jump_ena) begin
          m_pc    = jump_pc;
          holding = 0;
          if (outstanding) stale = 1;
        end
        prev_pend = imem_req_valid && !imem_req_ready;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    rst = 1'b0; if_pc_stall = 1'b0; jump_ena = 1'b0; jump_pc = '0;
    imem_req_ready = 1'b1; lat = 1; stray_req = 1'b0;

    // Streaming fetch, always ready, one-cycle response.
    do_reset();
    acc_log.delete(); vld_cyc.delete(); dlv_inst.delete();
    repeat (7) cyc();
    chk("s1_addr0", acc_log[0], 64'h8000_0000);
    chk("s1_addr1", acc_log[1], 64'h8000_0004);
    chk("s1_addr2", acc_log[2], 64'h8000_0008);
    chk("s1_n_valid", 64'(vld_cyc.size()), 64'd3);
    chk("s1_gap0", 64'(vld_cyc[1] - vld_cyc[0]), 64'd2);
    chk("s1_gap1", 64'(vld_cyc[2] - vld_cyc[1]), 64'd2);
    chk("s1_inst0", 64'(dlv_inst[0]), 64'h0010_0093);
    chk("s1_inst1", 64'(dlv_inst[1]), 64'h0010_0097);

    // Response held under a 3-cycle stall.
    do_reset();
    if_pc_stall = 1'b1;
    wait_accept("s2_first_addr", 64'h8000_0000);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      chk("s2_valid", 64'(if_valid), 64'd1);
      chk("s2_pc", if_pc, 64'h8000_0000);
      chk("s2_inst", 64'(if_inst), 64'h0010_0093);
      chk("s2_no_req", 64'(imem_req_valid), 64'd0);
    end
    cyc();
    if_pc_stall = 1'b0;
    @(negedge clk);
    chk("s2_release_valid", 64'(if_valid), 64'd1);
    chk("s2_release_no_req", 64'(imem_req_valid), 64'd0);
    lat = 3;
    wait_accept("s2_next_addr", 64'h8000_0004);

    // Redirect while waiting; the late response must be dropped.
    cyc();
    jump_ena = 1'b1; jump_pc = 64'h8000_0100;
    @(negedge clk);
    chk("s3_jump_valid", 64'(if_valid), 64'd0);
    cyc();
    jump_ena = 1'b0; lat = 1;
    cyc();
    @(negedge clk);
    chk("s3_drop", 64'(if_valid), 64'd0);
    chk("s3_no_req", 64'(imem_req_valid), 64'd0);
    wait_accept("s3_redirect_addr", 64'h8000_0100);

    // Redirect while holding a stalled pair.
    cyc();
    if_pc_stall = 1'b1;
    @(negedge clk);
    chk("s4_present", 64'(if_valid), 64'd1);
    chk("s4_pc", if_pc, 64'h8000_0100);
    cyc();
    jump_ena = 1'b1; jump_pc = 64'h8000_0200;
    @(negedge clk);
    chk("s4_jump_valid", 64'(if_valid), 64'd0);
    cyc();
    jump_ena = 1'b0; if_pc_stall = 1'b0;
    wait_accept("s4_redirect_addr", 64'h8000_0200);
    n = 0;
    foreach (cons_log[i]) if (cons_log[i] == 64'h8000_0100) n++;
    chk("s4_held_never_consumed", 64'(n), 64'd0);

    // Redirect of an unaccepted request, then PC wrap.
    cyc();
    imem_req_ready = 1'b0;
    cyc();
    jump_ena = 1'b1; jump_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    chk("s7_addr_before", imem_req_addr, 64'h8000_0204);
    cyc();
    jump_ena = 1'b0;
    @(negedge clk);
    chk("s7_req_valid", 64'(imem_req_valid), 64'd1);
    chk("s7_addr_switched", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc();
    imem_req_ready = 1'b1;
    wait_accept("s7_jump_addr", 64'hFFFF_FFFF_FFFF_FFFC);
    wait_accept("s7_wrap_addr", 64'h0);

    // Redirect in the same cycle the request is accepted.
    cyc();
    cyc();
    jump_ena = 1'b1; jump_pc = 64'h8000_0300;
    @(negedge clk);
    chk("s8_req_addr", imem_req_addr, 64'h4);
    cyc();
    jump_ena = 1'b0;
    @(negedge clk);
    chk("s8_drop", 64'(if_valid), 64'd0);
    wait_accept("s8_redirect_addr", 64'h8000_0300);

    // Request held for 4 cycles with ready low.
    imem_req_ready = 1'b0;
    do_reset();
    cyc();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s5_req_valid", 64'(imem_req_valid), 64'd1);
      chk("s5_addr", imem_req_addr, RST_PC);
      cyc();
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("s5_accept_valid", 64'(imem_req_valid), 64'd1);
    cyc();
    @(negedge clk);
    chk("s5_wait_no_req", 64'(imem_req_valid), 64'd0);
    chk("s5_deliver", 64'(if_valid), 64'd1);

    // Reset while waiting, then a stray response in IDLE.
    lat = 4;
    wait_accept("s6_addr", 64'h8000_0004);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("s6_rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("s6_rst_if_valid", 64'(if_valid), 64'd0);
    chk("s6_rst_if_pc", if_pc, RST_PC);
    chk("s6_rst_if_inst", 64'(if_inst), 64'd0);
    cyc();
    rst = 1'b1; stray_req = 1'b1;
    @(negedge clk);
    chk("s6_stray_valid", 64'(if_valid), 64'd0);
    chk("s6_idle_no_req", 64'(imem_req_valid), 64'd0);
    cyc();
    stray_req = 1'b0;
    @(negedge clk);
    chk("s6_req_valid", 64'(imem_req_valid), 64'd1);
    chk("s6_req_addr", imem_req_addr, RST_PC);
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
